// File: rtl/fft_peak_detector_pkg.sv
// Shared types, widths and helpers for the FFT peak detector.
// Holds ceil_log2, the FSM state encoding and default widths.
`timescale 1ns/1ps
package fft_pkg;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int WIDTH_DEF  = 10;
  localparam int POINTS_DEF = 32;
  localparam int LOGPTS = ceil_log2(POINTS_DEF);
  localparam int PWR_W  = 2 * WIDTH_DEF;
  localparam int SUM_W  = PWR_W + LOGPTS;

endpackage

// File: rtl/fft_peak_detector_if.sv
// Bundle of the FFT core read-out port and the peak result port.
// master: core/consumer side; slave: the peak detector.
`timescale 1ns/1ps
interface fft_peak_detector_if #(
  parameter int WIDTH  = 10,
  parameter int POINTS = 32
);
  import fft_pkg::*;

  localparam int LW = ceil_log2(POINTS);
  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + LW;

  logic                    OUTP_READY;
  logic                    DATAO_VALID;
  logic signed [WIDTH-1:0] DATAO_RE;
  logic signed [WIDTH-1:0] DATAO_IM;
  logic                    READ_OUTP;

  logic                    PEAK_VALID;
  logic                    PEAK_READY;
  logic [LW-1:0]           PEAK_BIN;
  logic [PW-1:0]           PEAK_PWR;
  logic [SW-1:0]           SUM_PWR;
  logic                    SHORT_FRAME;
  logic                    DROP;

  modport master (
    output OUTP_READY, DATAO_VALID,
    output DATAO_RE, DATAO_IM,
    output PEAK_READY,
    input  READ_OUTP, PEAK_VALID,
    input  PEAK_BIN, PEAK_PWR, SUM_PWR,
    input  SHORT_FRAME, DROP
  );

  modport slave (
    input  OUTP_READY, DATAO_VALID,
    input  DATAO_RE, DATAO_IM,
    input  PEAK_READY,
    output READ_OUTP, PEAK_VALID,
    output PEAK_BIN, PEAK_PWR, SUM_PWR,
    output SHORT_FRAME, DROP
  );

endinterface

// File: rtl/fft_peak_detector_bin_power.sv
// fft_bin_power: registered signed squares plus bin index sideband.
// Ports: clk_i, rst_ni, vld_i/re_i/im_i/idx_i in; vld_o/idx_o/pwr_o out.
`timescale 1ns/1ps
module fft_bin_power
  import fft_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int IDX_W = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    vld_i,
  input  logic signed [WIDTH-1:0] re_i,
  input  logic signed [WIDTH-1:0] im_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic                    vld_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic [2*WIDTH-1:0]      pwr_o
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] re_x, im_x;
  logic [PW-1:0]        re_sq, im_sq;
  logic [PW-1:0]        re2_q, im2_q;
  logic                 vld_q;
  logic [IDX_W-1:0]     idx_q;

  assign re_x  = PW'(re_i);
  assign im_x  = PW'(im_i);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re2_q <= '0;
      im2_q <= '0;
      vld_q <= 1'b0;
      idx_q <= '0;
    end else begin
      re2_q <= re_sq;
      im2_q <= im_sq;
      vld_q <= vld_i;
      idx_q <= idx_i;
    end
  end

  // Each square is at most 2^(2W-2), so the sum fits 2W bits.
  // The add is the second stage; the consumer registers it.
  assign pwr_o = re2_q + im2_q;
  assign vld_o = vld_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/fft_peak_detector.sv
// Peak search over one FFT frame: strongest bin, its power, total power.
// Ports: CLK, NGRST, bus (slave: core read-out in, result handshake out).
`timescale 1ns/1ps
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int POINTS  = 32,
  parameter bit EXCL_DC = 1'b0
) (
  input logic                CLK,
  input logic                NGRST,
  fft_peak_detector_if.slave bus
);

  localparam int LW = ceil_log2(POINTS);
  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + LW;

  state_e          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            fl_q, fl_d;
  logic            short_q, short_d;
  logic            pend_q, pend_d;
  logic            drop_q, drop_d;

  logic [LW-1:0]   mbin_q;
  logic [PW-1:0]   mpwr_q;
  logic [SW-1:0]   sum_q;

  logic            rd;
  logic            acc;
  logic            last;
  logic            drop_now;

  logic            p_vld;
  logic [LW-1:0]   p_idx;
  logic [PW-1:0]   p_pwr;
  logic            p_elig;

  assign rd = (state_q == ST_IDLE) ||
              (state_q == ST_ACCUM);
  assign acc      = bus.DATAO_VALID && rd;
  assign drop_now = bus.DATAO_VALID && !rd;
  assign last     = (cnt_q == LW'(POINTS - 1));

  fft_bin_power #(
    .WIDTH (WIDTH),
    .IDX_W (LW)
  ) u_pwr (
    .clk_i  (CLK),
    .rst_ni (NGRST),
    .vld_i  (acc),
    .re_i   (bus.DATAO_RE),
    .im_i   (bus.DATAO_IM),
    .idx_i  (cnt_q),
    .vld_o  (p_vld),
    .idx_o  (p_idx),
    .pwr_o  (p_pwr)
  );

  // cnt_q is zero whenever the FSM is idle, so the first
  // sample of a frame is tagged bin 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fl_d    = 1'b0;
    short_d = short_q;
    pend_d  = pend_q || drop_now;
    drop_d  = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        short_d = 1'b0;
        if (acc) begin
          state_d = ST_ACCUM;
          cnt_d   = LW'(1);
        end
      end
      ST_ACCUM: begin
        if (acc) cnt_d = cnt_q + LW'(1);
        // A full frame wins over a same-cycle OUTP_READY fall.
        if (acc && last) begin
          state_d = ST_FLUSH;
          short_d = 1'b0;
          cnt_d   = '0;
        end else if (!bus.OUTP_READY) begin
          state_d = ST_FLUSH;
          short_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        fl_d = !fl_q;
        if (fl_q) begin
          state_d = ST_HOLD;
          // Drops seen so far belong to this result;
          // later ones wait for the next one.
          drop_d  = pend_q || drop_now;
          pend_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (bus.PEAK_READY) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fl_q    <= 1'b0;
      short_q <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      short_q <= short_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign p_elig = !(EXCL_DC && (p_idx == '0));

  // Pipeline is empty while idle, so clearing here is safe.
  // Strict compare keeps the lowest bin on ties.
  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      mbin_q <= '0;
      mpwr_q <= '0;
      sum_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      mbin_q <= '0;
      mpwr_q <= '0;
      sum_q  <= '0;
    end else if (p_vld) begin
      sum_q <= sum_q + SW'(p_pwr);
      if (p_elig && (p_pwr > mpwr_q)) begin
        mpwr_q <= p_pwr;
        mbin_q <= p_idx;
      end
    end
  end

  assign bus.READ_OUTP   = rd;
  assign bus.PEAK_VALID  = (state_q == ST_HOLD);
  assign bus.PEAK_BIN    = mbin_q;
  assign bus.PEAK_PWR    = mpwr_q;
  assign bus.SUM_PWR     = sum_q;
  assign bus.SHORT_FRAME = short_q;
  assign bus.DROP        = drop_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector (EXCL_DC=0 and =1 side by side).
// Frames are modelled in plain arithmetic; a monitor pops and compares.
`timescale 1ns/1ps
module tb_fft_peak_detector;
  import fft_pkg::*;

  localparam int W = 10;
  localparam int N = 32;

  typedef struct {
    int     bin;
    longint pwr;
    longint sum;
    bit     shrt;
    bit     drop;
  } exp_t;

  logic CLK = 1'b0;
  logic NGRST = 1'b0;
  logic outp_ready = 1'b0;
  logic dv = 1'b0;
  logic pr = 1'b0;
  logic signed [W-1:0] re_d = '0;
  logic signed [W-1:0] im_d = '0;

  always #5 CLK = ~CLK;

  fft_peak_detector_if #(.WIDTH(W), .POINTS(N)) bus0 ();
  fft_peak_detector_if #(.WIDTH(W), .POINTS(N)) bus1 ();

  assign bus0.OUTP_READY  = outp_ready;
  assign bus0.DATAO_VALID = dv;
  assign bus0.DATAO_RE    = re_d;
  assign bus0.DATAO_IM    = im_d;
  assign bus0.PEAK_READY  = pr;
  assign bus1.OUTP_READY  = outp_ready;
  assign bus1.DATAO_VALID = dv;
  assign bus1.DATAO_RE    = re_d;
  assign bus1.DATAO_IM    = im_d;
  assign bus1.PEAK_READY  = pr;

  fft_peak_detector #(
    .WIDTH(W), .POINTS(N), .EXCL_DC(1'b0)
  ) dut0 (
    .CLK(CLK), .NGRST(NGRST), .bus(bus0)
  );

  fft_peak_detector #(
    .WIDTH(W), .POINTS(N), .EXCL_DC(1'b1)
  ) dut1 (
    .CLK(CLK), .NGRST(NGRST), .bus(bus1)
  );

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1, last0, last1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done0 = 0;
  int   pushed = 0;
  bit   drop_pend = 1'b0;
  int   fre[N];
  int   fim[N];

  function automatic exp_t model(input int n, input bit excl,
                                 input bit shrt, input bit drop);
    exp_t   r;
    longint p[N];
    longint mx;
    bit     found;
    mx    = 0;
    found = 1'b0;
    r.sum = 0;
    for (int i = 0; i < n; i++) begin
      p[i] = longint'(fre[i]) * fre[i] + longint'(fim[i]) * fim[i];
      r.sum += p[i];
      if (!(excl && i == 0) && p[i] > mx) mx = p[i];
    end
    r.pwr = mx;
    r.bin = 0;
    for (int i = 0; i < n; i++)
      if (!found && mx > 0 && !(excl && i == 0) && p[i] == mx) begin
        r.bin = i;
        found = 1'b1;
      end
    r.shrt = shrt;
    r.drop = drop;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (NGRST && bus0.PEAK_VALID && bus0.PEAK_READY) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut0 spurious: got bin %0d, required none",
                 bus0.PEAK_BIN);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 bin", longint'(bus0.PEAK_BIN), e0.bin);
        chk("dut0 pwr", longint'(bus0.PEAK_PWR), e0.pwr);
        chk("dut0 sum", longint'(bus0.SUM_PWR), e0.sum);
        chk("dut0 short", longint'(bus0.SHORT_FRAME), e0.shrt);
        chk("dut0 drop", longint'(bus0.DROP), e0.drop);
      end
      done0++;
    end
    if (NGRST && bus1.PEAK_VALID && bus1.PEAK_READY) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1 spurious: got bin %0d, required none",
                 bus1.PEAK_BIN);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 bin", longint'(bus1.PEAK_BIN), e1.bin);
        chk("dut1 pwr", longint'(bus1.PEAK_PWR), e1.pwr);
        chk("dut1 sum", longint'(bus1.SUM_PWR), e1.sum);
        chk("dut1 short", longint'(bus1.SHORT_FRAME), e1.shrt);
        chk("dut1 drop", longint'(bus1.DROP), e1.drop);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input int amp);
    for (int i = 0; i < N; i++) begin
      if (amp == 0) begin
        fre[i] = 0;
        fim[i] = 0;
      end else begin
        fre[i] = int'($urandom_range(0, 2 * amp - 1)) - amp;
        fim[i] = int'($urandom_range(0, 2 * amp - 1)) - amp;
      end
    end
  endtask

  task automatic send_frame(input int n, input bit shrt,
                            input bit fall_last);
    last0 = model(n, 1'b0, shrt, drop_pend);
    last1 = model(n, 1'b1, shrt, drop_pend);
    q0.push_back(last0);
    q1.push_back(last1);
    drop_pend = 1'b0;
    pushed++;
    outp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      dv   = 1'b1;
      re_d = W'(fre[i]);
      im_d = W'(fim[i]);
      if (fall_last && i == n - 1) outp_ready = 1'b0;
      tick();
    end
    dv = 1'b0;
    outp_ready = 1'b0;
  endtask

  task automatic wait_result(input bit rnd);
    int k;
    k = 0;
    do begin
      if (rnd) pr = 1'($urandom_range(0, 1));
      tick();
      k++;
    end while (done0 < pushed && k < 400);
    if (done0 < pushed) begin
      n_tests++;
      n_fail++;
      $display("FAIL result timeout: got %0d results, required %0d",
               done0, pushed);
      done0 = pushed;
    end
  endtask

  task automatic check_reset();
    @(negedge CLK);
    chk("rst read_outp", longint'(bus0.READ_OUTP), 1);
    chk("rst valid", longint'(bus0.PEAK_VALID), 0);
    chk("rst bin", longint'(bus0.PEAK_BIN), 0);
    chk("rst pwr", longint'(bus0.PEAK_PWR), 0);
    chk("rst sum", longint'(bus0.SUM_PWR), 0);
    chk("rst short", longint'(bus0.SHORT_FRAME), 0);
    chk("rst drop", longint'(bus0.DROP), 0);
    chk("rst valid dut1", longint'(bus1.PEAK_VALID), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int k;
    int len;
    check_reset();
    tick();
    NGRST = 1'b1;
    tick();

    // single tone with latency and handshake timing
    for (int i = 0; i < N; i++) begin
      fre[i] = 1;
      fim[i] = 1;
    end
    fre[5] = 100;
    fim[5] = -50;
    pr = 1'b1;
    send_frame(N, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      chk("latency valid", longint'(bus0.PEAK_VALID), (i == 3));
      if (i == 1)
        chk("read_outp flush", longint'(bus0.READ_OUTP), 0);
    end
    wait_result(1'b0);
    @(negedge CLK);
    chk("read_outp after hs", longint'(bus0.READ_OUTP), 1);
    chk("hold one cycle", longint'(bus0.PEAK_VALID), 0);

    // tie at full negative range
    fill(100);
    fre[3] = -512;
    fim[3] = 0;
    fre[20] = -512;
    fim[20] = 0;
    send_frame(N, 1'b0, 1'b0);
    wait_result(1'b1);

    // short frame of 20 bins
    fill(512);
    send_frame(20, 1'b1, 1'b0);
    wait_result(1'b1);

    // OUTP_READY falls with the last sample
    fill(512);
    send_frame(N, 1'b0, 1'b1);
    wait_result(1'b1);

    // DC bin dominant
    fill(0);
    fre[0] = 200;
    fim[0] = 200;
    fre[7] = 10;
    pr = 1'b1;
    send_frame(N, 1'b0, 1'b0);
    wait_result(1'b0);

    // all-zero frame
    fill(0);
    send_frame(N, 1'b0, 1'b0);
    wait_result(1'b1);

    // backpressure with samples pulsed during HOLD
    pr = 1'b0;
    fill(512);
    send_frame(N, 1'b0, 1'b0);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!bus0.PEAK_VALID && k < 20);
    chk("hold reached", longint'(bus0.PEAK_VALID), 1);
    for (int c = 0; c < 10; c++) begin
      chk("hold read_outp", longint'(bus0.READ_OUTP), 0);
      chk("hold valid", longint'(bus0.PEAK_VALID), 1);
      chk("hold bin", longint'(bus0.PEAK_BIN), last0.bin);
      chk("hold pwr", longint'(bus0.PEAK_PWR), last0.pwr);
      chk("hold sum", longint'(bus0.SUM_PWR), last0.sum);
      @(posedge CLK);
      #1;
      dv = (c % 3 == 0);
      re_d = W'(int'($urandom_range(0, 1023)) - 512);
      if (dv) drop_pend = 1'b1;
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    dv = 1'b0;
    pr = 1'b1;
    wait_result(1'b0);

    // next result carries DROP, the one after does not
    fill(300);
    send_frame(N, 1'b0, 1'b0);
    wait_result(1'b1);
    fill(512);
    send_frame(17, 1'b1, 1'b0);
    wait_result(1'b1);

    // OUTP_READY pulse in IDLE produces nothing
    pr = 1'b1;
    outp_ready = 1'b1;
    tick();
    outp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("idle no result", longint'(bus0.PEAK_VALID), 0);
    end

    // reset in the middle of a frame
    tick();
    fill(512);
    outp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      dv = 1'b1;
      re_d = W'(fre[i]);
      im_d = W'(fim[i]);
      tick();
    end
    NGRST = 1'b0;
    dv = 1'b0;
    outp_ready = 1'b0;
    check_reset();
    tick();
    NGRST = 1'b1;
    drop_pend = 1'b0;
    pr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("no valid after rst", longint'(bus0.PEAK_VALID), 0);
    end
    tick();
    fill(512);
    send_frame(N, 1'b0, 1'b0);
    wait_result(1'b1);

    // random frames, some short
    for (int f = 0; f < 8; f++) begin
      len = ($urandom_range(0, 1) == 1) ? N
            : int'($urandom_range(16, N - 1));
      fill(512);
      send_frame(len, (len < N), 1'b0);
      wait_result(1'b1);
    end

    pr = 1'b1;
    repeat (6) tick();
    chk("queues drained", longint'(q0.size() + q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_peak_detector.md
# fft_peak_detector

Downstream consumer of the in-place CoreFFT output port. It paces result read-out via READ_OUTP and computes per-bin power re²+im² over one FFT frame. It reports the strongest bin index, its power and the frame's total power through a valid/ready result port. It is the coarse acquisition stage for the GNSS correlation path.

## Interface
Parameters:
- WIDTH, 10, bit width of DATAO_RE / DATAO_IM (signed two's complement)
- POINTS, 32, FFT size; bins per frame (power of two, 16..4096)
- EXCL_DC, 0, 1 = bin 0 is excluded from the peak search (still added to SUM_PWR)

Ports:
- CLK  in  1  single clock, shared with the FFT core
- NGRST  in  1  asynchronous active-low reset
- OUTP_READY  in  1  from core; high while a result frame is available
- DATAO_VALID  in  1  from core; qualifies DATAO_RE / DATAO_IM
- DATAO_RE  in  WIDTH  real part of the FFT output
- DATAO_IM  in  WIDTH  imaginary part of the FFT output
- READ_OUTP  out  1  to core; high = detector accepts output samples
- PEAK_VALID  out  1  result valid
- PEAK_READY  in  1  result accepted when high together with PEAK_VALID
- PEAK_BIN  out  LOGPTS  index of the maximum-power bin
- PEAK_PWR  out  2*WIDTH  power of that bin (the power of a signed WIDTH pair fits in 2*WIDTH bits unsigned)
- SUM_PWR  out  2*WIDTH+LOGPTS  sum of all bin powers in the frame
- SHORT_FRAME  out  1  frame ended with fewer than POINTS valid samples
- DROP  out  1  a DATAO_VALID arrived while READ_OUTP was low

## Operation
- LOGPTS = ceil_log2(POINTS).
- FSM states:
  - IDLE: counters and max cleared.
  - ACCUM: accepting samples.
  - FLUSH: 2 cycles while the pipeline empties.
  - HOLD: result presented.
- IDLE→ACCUM on the first DATAO_VALID.
- ACCUM→FLUSH when the POINTS-th valid sample is taken, or when OUTP_READY falls with the bin count below POINTS. In the second case SHORT_FRAME=1.
- FLUSH→HOLD after 2 cycles.
- HOLD→IDLE on PEAK_VALID & PEAK_READY.
- READ_OUTP = 1 in IDLE and ACCUM; 0 in FLUSH and HOLD.
- Bin index is the count of accepted valid samples since frame start, 0..POINTS-1. Natural output order (ORDER=1) is required of the core.
- Pipeline:
  - stage 1 registers re², im² and the bin index;
  - stage 2 adds them into pwr, accumulates SUM_PWR, and updates the max when pwr > current max.
  - The comparison is strict, so on ties the lowest bin wins.
- Max register initial value is 0, bin 0. If every bin has zero power (or all are excluded), PEAK_BIN=0 and PEAK_PWR=0.
- SUM_PWR has no overflow; the width is sized for POINTS × (2^(2*WIDTH-2)+...) worst case.
- DATAO_VALID with READ_OUTP=0 is ignored and sets DROP. DROP is sticky until the current result is accepted, and is then carried into the next result.
- PEAK_* outputs are stable throughout HOLD.

## Timing
- Reset values (async, NGRST low): state IDLE, READ_OUTP=1, PEAK_VALID=0, PEAK_BIN=0, PEAK_PWR=0, SUM_PWR=0, SHORT_FRAME=0, DROP=0, all counters 0.
- Latency: last sample accepted at cycle t → pipeline stage 2 done at t+2 → PEAK_VALID=1 from t+3.
- READ_OUTP drops at t+1 and rises the cycle after the handshake.
- If PEAK_READY is already high when PEAK_VALID rises, the result is consumed in that cycle; HOLD lasts 1 cycle.
- OUTP_READY fall in the same cycle as the POINTS-th sample: treated as a complete frame, SHORT_FRAME=0.
- OUTP_READY low in IDLE: no action. An OUTP_READY fall in IDLE (zero samples) produces no result.
- Reset mid-frame: all partial state is discarded, with no spurious PEAK_VALID after release.

## Structure
- Shared package fft_pkg: ceil_log2 function, FSM state encoding, and the width localparams LOGPTS, PWR_W=2*WIDTH, SUM_W=PWR_W+LOGPTS.
- One sub-module, fft_bin_power: the 2-stage signed square-and-add pipeline with a valid/index sideband.
- Top level holds the FSM, counters, max/sum registers and result handshake.

## Test plan
- Single tone: POINTS=32, bin 5 = (100,−50), all others (1,1) → PEAK_BIN=5, PEAK_PWR=12500, SUM_PWR=12500+31×2=12562, PEAK_VALID 3 cycles after the last sample.
- Tie: bins 3 and 20 both (−512,0) → PEAK_BIN=3, PEAK_PWR=262144; full negative range squared correctly.
- Short frame: OUTP_READY falls after 20 valid samples → result issued with SHORT_FRAME=1 and SUM covering 20 bins only.
- Backpressure: PEAK_READY held low for 10 cycles; core pulses DATAO_VALID during HOLD → READ_OUTP=0 throughout, outputs stable, DROP=1 on the next result.
- EXCL_DC=1: bin 0 = (200,200), bin 7 = (10,0) → PEAK_BIN=7, PEAK_PWR=100, SUM includes 80000.
- Reset asserted mid-ACCUM (bin 12), then a full frame → only one result, for the new frame; reset values checked during NGRST low.
